// File: rtl/result_fwd_net_pkg.sv
// Shared types and defaults for the result-forwarding network.
package result_fwd_net_pkg;

    localparam int unsigned NPIPE_DEF = 2;
    localparam int unsigned DEPTH_DEF = 7;
    localparam int unsigned DW_DEF    = 128;
    localparam int unsigned AW_DEF    = 7;
    localparam int unsigned NSRC_DEF  = 3;
    localparam int unsigned LATW_DEF  = 4;

    localparam int unsigned PIPE_EVEN = 0;
    localparam int unsigned PIPE_ODD  = 1;

    // One in-flight destination tracked per pipe stage
    typedef struct packed {
        logic                valid;
        logic                wr_en;
        logic [AW_DEF-1:0]   rt_addr;
        logic [LATW_DEF-1:0] lat;
        logic                ready;
        logic [DW_DEF-1:0]   data;
    } fwd_slot_t;

endpackage

// File: rtl/result_fwd_net_fwd_select.sv
// Per-operand priority comparator: candidate 0 has the highest priority.
module result_fwd_net_fwd_select #(
    parameter int unsigned NCAND = 12,
    parameter int unsigned DW    = 128,
    parameter int unsigned AW    = 7
) (
    input  logic [NCAND-1:0]         cand_en,
    input  logic [NCAND-1:0][AW-1:0] cand_rt,
    input  logic [NCAND-1:0]         cand_ready,
    input  logic [NCAND-1:0][DW-1:0] cand_data,
    input  logic [AW-1:0]            rd_addr,
    input  logic [DW-1:0]            rf_data,
    output logic [DW-1:0]            op_data,
    output logic                     hazard
);

    // Scan from lowest to highest priority so the last hit is the winner
    always_comb begin
        op_data = rf_data;
        hazard  = 1'b0;
        for (int i = int'(NCAND) - 1; i >= 0; i--) begin
            if (cand_en[i] && (cand_rt[i] == rd_addr)) begin
                hazard  = ~cand_ready[i];
                op_data = cand_ready[i] ? cand_data[i] : rf_data;
            end
        end
    end

endmodule

// File: rtl/result_fwd_net.sv
// NPIPE x DEPTH result-forwarding network with stall and writeback.
// Build option: RESULT_FWD_WB_BYPASS_EN adds stage-DEPTH slots to forwarding.
module result_fwd_net
    import result_fwd_net_pkg::*;
#(
    parameter int unsigned NPIPE = NPIPE_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned NSRC  = NSRC_DEF,
    parameter int unsigned LATW  = LATW_DEF
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NPIPE-1:0]                  iss_valid,
    input  logic [NPIPE-1:0]                  iss_wr_en,
    input  logic [NPIPE-1:0][AW-1:0]          iss_rt_addr,
    input  logic [NPIPE-1:0][LATW-1:0]        iss_lat,
    input  logic [NPIPE-1:0]                  res_we,
    input  logic [NPIPE-1:0][LATW-1:0]        res_stage,
    input  logic [NPIPE-1:0][DW-1:0]          res_data,
    input  logic [NPIPE-1:0]                  flush_kill,
    input  logic [NPIPE-1:0][NSRC-1:0][AW-1:0] rd_addr,
    input  logic [NPIPE-1:0][NSRC-1:0][DW-1:0] rf_data,
    output logic [NPIPE-1:0][NSRC-1:0][DW-1:0] op_data,
    output logic                              stall,
    output logic [NPIPE-1:0]                  wb_valid,
    output logic [NPIPE-1:0][AW-1:0]          wb_addr,
    output logic [NPIPE-1:0][DW-1:0]          wb_data
);

`ifdef RESULT_FWD_WB_BYPASS_EN
    localparam int unsigned NFWD = DEPTH;
`else
    localparam int unsigned NFWD = DEPTH - 1;
`endif
    localparam int unsigned NCAND = NFWD * NPIPE;

    // Index s holds the slot that is in stage s+1
    fwd_slot_t slot_q [NPIPE][DEPTH];
    fwd_slot_t slot_d [NPIPE][DEPTH];

    always_comb begin
        for (int p = 0; p < NPIPE; p++) begin
            slot_d[p][0] = '0;
            if (iss_valid[p]) begin
                slot_d[p][0].valid   = 1'b1;
                slot_d[p][0].wr_en   = iss_wr_en[p];
                slot_d[p][0].rt_addr = AW_DEF'(iss_rt_addr[p]);
                slot_d[p][0].lat     = LATW_DEF'(iss_lat[p]);
            end
            for (int s = 1; s < DEPTH; s++) begin
                slot_d[p][s] = slot_q[p][s-1];
                // Result for the slot now in stage s lands as it advances
                if (res_we[p] && slot_q[p][s-1].valid &&
                    (res_stage[p] == LATW'(s)) &&
                    (slot_q[p][s-1].lat == LATW_DEF'(res_stage[p]))) begin
                    slot_d[p][s].ready = 1'b1;
                    slot_d[p][s].data  = DW_DEF'(res_data[p]);
                end
            end
            if (flush_kill[p]) begin
                slot_d[p][1].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NPIPE; p++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    slot_q[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NPIPE; p++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    slot_q[p][s] <= slot_d[p][s];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NPIPE; p++) begin
            wb_valid[p] = slot_q[p][DEPTH-1].valid & slot_q[p][DEPTH-1].wr_en &
                          slot_q[p][DEPTH-1].ready;
            wb_addr[p]  = AW'(slot_q[p][DEPTH-1].rt_addr);
            wb_data[p]  = DW'(slot_q[p][DEPTH-1].data);
        end
    end

    logic [NCAND-1:0]         cand_en;
    logic [NCAND-1:0][AW-1:0] cand_rt;
    logic [NCAND-1:0]         cand_ready;
    logic [NCAND-1:0][DW-1:0] cand_data;

    // Priority order: younger stage first, then higher pipe index
    always_comb begin
        cand_en    = '0;
        cand_rt    = '0;
        cand_ready = '0;
        cand_data  = '0;
        for (int s = 0; s < NFWD; s++) begin
            for (int p = 0; p < NPIPE; p++) begin
                cand_en[s*NPIPE + NPIPE - 1 - p]    = slot_q[p][s].valid & slot_q[p][s].wr_en;
                cand_rt[s*NPIPE + NPIPE - 1 - p]    = AW'(slot_q[p][s].rt_addr);
                cand_ready[s*NPIPE + NPIPE - 1 - p] = slot_q[p][s].ready;
                cand_data[s*NPIPE + NPIPE - 1 - p]  = DW'(slot_q[p][s].data);
            end
        end
    end

    logic [NPIPE*NSRC-1:0] hazard;

    for (genvar p = 0; p < NPIPE; p++) begin : gen_pipe
        for (genvar r = 0; r < NSRC; r++) begin : gen_src
            result_fwd_net_fwd_select #(
                .NCAND (NCAND),
                .DW    (DW),
                .AW    (AW)
            ) u_sel (
                .cand_en    (cand_en),
                .cand_rt    (cand_rt),
                .cand_ready (cand_ready),
                .cand_data  (cand_data),
                .rd_addr    (rd_addr[p][r]),
                .rf_data    (rf_data[p][r]),
                .op_data    (op_data[p][r]),
                .hazard     (hazard[p*NSRC + r])
            );
        end
    end

    assign stall = |hazard;

endmodule

// File: tb/tb_result_fwd_net.sv
// Bench for result_fwd_net: directed scenarios plus random traffic vs an instruction-level model.
module tb_result_fwd_net;

    localparam int NPIPE = 2;
    localparam int DEPTH = 7;
    localparam int DW    = 128;
    localparam int AW    = 7;
    localparam int NSRC  = 3;
    localparam int LATW  = 4;
`ifdef RESULT_FWD_WB_BYPASS_EN
    localparam int MAXFWD = DEPTH;
`else
    localparam int MAXFWD = DEPTH - 1;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [NPIPE-1:0]                   iss_valid;
    logic [NPIPE-1:0]                   iss_wr_en;
    logic [NPIPE-1:0][AW-1:0]           iss_rt_addr;
    logic [NPIPE-1:0][LATW-1:0]         iss_lat;
    logic [NPIPE-1:0]                   res_we;
    logic [NPIPE-1:0][LATW-1:0]         res_stage;
    logic [NPIPE-1:0][DW-1:0]           res_data;
    logic [NPIPE-1:0]                   flush_kill;
    logic [NPIPE-1:0][NSRC-1:0][AW-1:0] rd_addr;
    logic [NPIPE-1:0][NSRC-1:0][DW-1:0] rf_data;
    logic [NPIPE-1:0][NSRC-1:0][DW-1:0] op_data;
    logic                               stall;
    logic [NPIPE-1:0]                   wb_valid;
    logic [NPIPE-1:0][AW-1:0]           wb_addr;
    logic [NPIPE-1:0][DW-1:0]           wb_data;

    int vectors     = 0;
    int miscompares = 0;

    // In-flight instruction as seen by the model: age is its current stage
    typedef struct {
        int           pipe;
        int           age;
        bit           wr_en;
        int           rt;
        int           lat;
        bit           ready;
        logic [DW-1:0] data;
    } ent_t;
    ent_t q[$];

    always #5 clock = ~clock;

    result_fwd_net #(
        .NPIPE (NPIPE), .DEPTH (DEPTH), .DW (DW), .AW (AW), .NSRC (NSRC), .LATW (LATW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iss_valid   (iss_valid),
        .iss_wr_en   (iss_wr_en),
        .iss_rt_addr (iss_rt_addr),
        .iss_lat     (iss_lat),
        .res_we      (res_we),
        .res_stage   (res_stage),
        .res_data    (res_data),
        .flush_kill  (flush_kill),
        .rd_addr     (rd_addr),
        .rf_data     (rf_data),
        .op_data     (op_data),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < (DW + 31) / 32; i++) v = (v << 32) | DW'($urandom);
        return v;
    endfunction

    // Advance every in-flight instruction one stage using the current inputs
    function automatic void model_edge();
        ent_t nq[$];
        ent_t e;
        for (int i = 0; i < q.size(); i++) begin
            e = q[i];
            if (res_we[e.pipe] && int'(res_stage[e.pipe]) == e.age && e.lat == e.age) begin
                e.ready = 1'b1;
                e.data  = res_data[e.pipe];
            end
            if (!(flush_kill[e.pipe] && e.age == 1) && e.age < DEPTH) begin
                e.age = e.age + 1;
                nq.push_back(e);
            end
        end
        for (int p = 0; p < NPIPE; p++) begin
            if (iss_valid[p]) begin
                e.pipe  = p;
                e.age   = 1;
                e.wr_en = iss_wr_en[p];
                e.rt    = int'(iss_rt_addr[p]);
                e.lat   = int'(iss_lat[p]);
                e.ready = 1'b0;
                e.data  = '0;
                nq.push_back(e);
            end
        end
        q = nq;
    endfunction

    function automatic void model_fwd(input int pp, input int rr, output bit hz, output logic [DW-1:0] val);
        int best;
        best = -1;
        hz   = 1'b0;
        val  = rf_data[pp][rr];
        foreach (q[i]) begin
            if (q[i].wr_en && q[i].rt == int'(rd_addr[pp][rr]) && q[i].age <= MAXFWD) begin
                if (best < 0 || q[i].age < q[best].age ||
                    (q[i].age == q[best].age && q[i].pipe > q[best].pipe))
                    best = i;
            end
        end
        if (best >= 0) begin
            hz  = !q[best].ready;
            val = q[best].ready ? q[best].data : rf_data[pp][rr];
        end
    endfunction

    function automatic void model_wb(input int p, output bit v, output int a, output logic [DW-1:0] d);
        v = 1'b0;
        a = 0;
        d = '0;
        foreach (q[i]) begin
            if (q[i].pipe == p && q[i].age == DEPTH && q[i].wr_en && q[i].ready) begin
                v = 1'b1;
                a = q[i].rt;
                d = q[i].data;
            end
        end
    endfunction

    task automatic set_idle();
        for (int p = 0; p < NPIPE; p++) begin
            iss_valid[p]   = 1'b0;
            iss_wr_en[p]   = 1'b0;
            iss_rt_addr[p] = '0;
            iss_lat[p]     = '0;
            res_we[p]      = 1'b0;
            res_stage[p]   = '0;
            res_data[p]    = '0;
            flush_kill[p]  = 1'b0;
            for (int r = 0; r < NSRC; r++) begin
                rd_addr[p][r] = AW'(100);
                rf_data[p][r] = rnd_data();
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        set_idle();
    endtask

    task automatic drain();
        repeat (DEPTH + 1) next_cycle();
    endtask

    task automatic issue(input int p, input int rt, input int lat);
        iss_valid[p]   = 1'b1;
        iss_wr_en[p]   = 1'b1;
        iss_rt_addr[p] = AW'(rt);
        iss_lat[p]     = LATW'(lat);
    endtask

    task automatic deliver(input int p, input int stg, input logic [DW-1:0] d);
        res_we[p]    = 1'b1;
        res_stage[p] = LATW'(stg);
        res_data[p]  = d;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        set_idle();
        #1;
        vectors++;
        if (wb_valid !== '0 || wb_addr !== '0 || wb_data !== '0) begin
            miscompares++;
            $display("FAIL reset_wb: got valid=%b addr=%h want all zero", wb_valid, wb_addr);
        end
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stall: got %b want 0", stall);
        end
        vectors++;
        if (op_data !== rf_data) begin
            miscompares++;
            $display("FAIL reset_op: op_data does not equal rf_data");
        end
        reset = 1'b1;
        q.delete();
    endtask

    task automatic test_fwd_basic();
        logic [DW-1:0] aa;
        aa = {(DW/8){8'hAA}};
        issue(0, 5, 2);
        next_cycle();
        next_cycle();
        rd_addr[0][0] = AW'(5);
        deliver(0, 2, aa);
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_stall: got %b want 1", stall);
        end
        next_cycle();
        rd_addr[0][0] = AW'(5);
        #1;
        vectors++;
        if (stall !== 1'b0 || op_data[0][0] !== aa) begin
            miscompares++;
            $display("FAIL basic_fwd: got stall=%b op=%h want stall=0 op=%h", stall, op_data[0][0], aa);
        end
        repeat (3) next_cycle();
        #1;
        vectors++;
        if (wb_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_wb_early: got %b want 0", wb_valid[0]);
        end
        next_cycle();
        #1;
        vectors++;
        if (wb_valid[0] !== 1'b1 || wb_addr[0] !== AW'(5) || wb_data[0] !== aa) begin
            miscompares++;
            $display("FAIL basic_wb: got v=%b a=%0d d=%h want v=1 a=5 d=%h", wb_valid[0], wb_addr[0], wb_data[0], aa);
        end
        next_cycle();
        #1;
        vectors++;
        if (wb_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_wb_late: got %b want 0", wb_valid[0]);
        end
    endtask

    task automatic test_pipe_priority();
        issue(1, 9, 1);
        next_cycle();
        deliver(1, 1, DW'(2));
        next_cycle();
        issue(0, 9, 2);
        next_cycle();
        next_cycle();
        deliver(0, 2, DW'(1));
        next_cycle();
        rd_addr[1][2] = AW'(9);
        #1;
        vectors++;
        if (stall !== 1'b0 || op_data[1][2] !== DW'(1)) begin
            miscompares++;
            $display("FAIL stage_priority: got stall=%b op=%h want stall=0 op=1", stall, op_data[1][2]);
        end
    endtask

    task automatic test_same_stage();
        issue(0, 12, 1);
        issue(1, 12, 1);
        next_cycle();
        deliver(0, 1, DW'(3));
        deliver(1, 1, DW'(4));
        next_cycle();
        rd_addr[0][1] = AW'(12);
        #1;
        vectors++;
        if (stall !== 1'b0 || op_data[0][1] !== DW'(4)) begin
            miscompares++;
            $display("FAIL same_stage_fwd: got stall=%b op=%h want stall=0 op=4", stall, op_data[0][1]);
        end
        repeat (5) next_cycle();
        #1;
        vectors++;
        if (wb_valid !== 2'b11 || wb_addr[1] !== AW'(12) || wb_data[1] !== DW'(4) || wb_data[0] !== DW'(3)) begin
            miscompares++;
            $display("FAIL same_stage_wb: got v=%b d1=%h d0=%h want v=11 d1=4 d0=3", wb_valid, wb_data[1], wb_data[0]);
        end
    endtask

    task automatic test_flush();
        issue(0, 7, 3);
        next_cycle();
        flush_kill[0] = 1'b1;
        next_cycle();
        for (int k = 2; k <= 8; k++) begin
            rd_addr[0][0] = AW'(7);
            if (k == 3) deliver(0, 3, DW'(7));
            #1;
            vectors++;
            if (stall !== 1'b0 || wb_valid[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_k%0d: got stall=%b wb=%b want 0 0", k, stall, wb_valid[0]);
            end
            next_cycle();
        end
    endtask

    task automatic test_bad_capture();
        issue(0, 20, 3);
        next_cycle();
        next_cycle();
        for (int k = 2; k <= 8; k++) begin
            rd_addr[0][0] = AW'(20);
            if (k == 2) deliver(0, 2, DW'(9));
            if (k == 3) deliver(0, 2, DW'(9));
            #1;
            if (k <= 6) begin
                vectors++;
                if (stall !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bad_capture_stall_k%0d: got %b want 1", k, stall);
                end
            end
            vectors++;
            if (wb_valid[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL bad_capture_wb_k%0d: got %b want 0", k, wb_valid[0]);
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        bit            hz;
        bit            any;
        bit            wv;
        int            wa;
        int            found;
        logic [DW-1:0] ev;
        logic [DW-1:0] wd;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < NPIPE; p++) begin
                for (int r = 0; r < NSRC; r++) rd_addr[p][r] = AW'($urandom_range(0, 9));
                found = -1;
                foreach (q[i]) if (q[i].pipe == p && q[i].age == q[i].lat) found = i;
                if (found >= 0 && $urandom_range(0, 9) < 8)
                    deliver(p, q[found].lat, rnd_data());
                else if ($urandom_range(0, 9) == 0)
                    deliver(p, $urandom_range(1, DEPTH - 1), rnd_data());
                flush_kill[p] = ($urandom_range(0, 15) == 0);
            end
            #1;
            any = 1'b0;
            for (int p = 0; p < NPIPE; p++) begin
                for (int r = 0; r < NSRC; r++) begin
                    model_fwd(p, r, hz, ev);
                    any = any | hz;
                    if (!hz) begin
                        vectors++;
                        if (op_data[p][r] !== ev) begin
                            miscompares++;
                            $display("FAIL rand_op c%0d p%0d r%0d: got %h want %h", cyc, p, r, op_data[p][r], ev);
                        end
                    end
                end
            end
            vectors++;
            if (stall !== any) begin
                miscompares++;
                $display("FAIL rand_stall c%0d: got %b want %b", cyc, stall, any);
            end
            for (int p = 0; p < NPIPE; p++) begin
                model_wb(p, wv, wa, wd);
                vectors++;
                if (wb_valid[p] !== wv || (wv && (wb_addr[p] !== AW'(wa) || wb_data[p] !== wd))) begin
                    miscompares++;
                    $display("FAIL rand_wb c%0d p%0d: got v=%b a=%0d d=%h want v=%b a=%0d d=%h",
                             cyc, p, wb_valid[p], wb_addr[p], wb_data[p], wv, wa, wd);
                end
            end
            if (!any) begin
                for (int p = 0; p < NPIPE; p++) begin
                    if ($urandom_range(0, 2) != 0) begin
                        issue(p, $urandom_range(0, 7), $urandom_range(1, DEPTH - 1));
                        iss_wr_en[p] = ($urandom_range(0, 9) != 0);
                    end
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_midflight();
        issue(0, 31, 1);
        issue(1, 32, 1);
        next_cycle();
        deliver(0, 1, DW'(31));
        deliver(1, 1, DW'(32));
        issue(0, 33, 1);
        issue(1, 30, 5);
        next_cycle();
        deliver(0, 1, DW'(33));
        repeat (5) next_cycle();
        rd_addr[0][0] = AW'(30);
        #1;
        vectors++;
        if (wb_valid !== 2'b11 || stall !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: got wb=%b stall=%b want 11 1", wb_valid, stall);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (wb_valid !== '0 || wb_addr !== '0 || wb_data !== '0) begin
            miscompares++;
            $display("FAIL midreset_wb: got v=%b addr=%h want all zero", wb_valid, wb_addr);
        end
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_stall: got %b want 0", stall);
        end
        vectors++;
        if (op_data !== rf_data) begin
            miscompares++;
            $display("FAIL midreset_op: op_data[0][0]=%h rf_data[0][0]=%h", op_data[0][0], rf_data[0][0]);
        end
        q.delete();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        set_idle();
        rd_addr[0][0] = AW'(30);
        #1;
        vectors++;
        if (stall !== 1'b0 || wb_valid !== '0) begin
            miscompares++;
            $display("FAIL post_reset: got stall=%b wb=%b want 0 00", stall, wb_valid);
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_fwd_basic();
        drain();
        test_pipe_priority();
        drain();
        test_same_stage();
        drain();
        test_flush();
        drain();
        test_bad_capture();
        drain();
        test_random();
        drain();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
